// File: rtl/crack_sched.sv
//----------------------------------------------------------------------------
// Module      : crack_sched
// Description : Launches NUM_CORES ARC4 crack cores over a partitioned key
//               space. Core i starts at key_base+i and steps by NUM_CORES.
//               Round-robin arbitrates the shared ciphertext read port,
//               reports the first valid key and aborts the other cores.
//               Optional performance counters: CRACK_SCHED_PERF_EN.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module crack_sched #(
  parameter int NUM_CORES = 2,
  parameter int KEY_W     = 24,
  parameter int ADDR_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic                        rdy,
  input  logic [KEY_W-1:0]            key_base,
  output logic [KEY_W-1:0]            key,
  output logic                        key_valid,
  output logic [NUM_CORES-1:0]        core_en,
  output logic [NUM_CORES-1:0]        core_abort,
  output logic [NUM_CORES*KEY_W-1:0]  core_key_start,
  input  logic [NUM_CORES-1:0]        core_rdy,
  input  logic [NUM_CORES-1:0]        core_key_valid,
  input  logic [NUM_CORES*KEY_W-1:0]  core_key,
  input  logic [NUM_CORES-1:0]        core_ct_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_ct_addr,
  output logic [NUM_CORES-1:0]        core_ct_gnt,
  output logic [NUM_CORES-1:0]        core_ct_rvalid,
  output logic [7:0]                  ct_rddata_o,
  output logic [ADDR_W-1:0]           ct_addr,
  input  logic [7:0]                  ct_rddata
`ifdef CRACK_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_cycles,
  output logic [31:0]                 perf_stall
`endif
);

  // Pointer width; kept at least one bit so a single-core build stays legal.
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [KEY_W-1:0]     key_base_q;
  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] busy_nxt;
  logic                 first_run;
  logic                 all_rdy;
  logic                 launch;
  logic [NUM_CORES-1:0] done_mask;
  logic [NUM_CORES-1:0] valid_fin;
  logic                 win_any;
  logic [PTR_W-1:0]     win_idx;
  logic [KEY_W-1:0]     win_key;

  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] gnt;
  logic                 gnt_any;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     scan_idx;
  logic [ADDR_W-1:0]    addr_hold;
  logic [NUM_CORES-1:0] rvalid;

  assign all_rdy = &core_rdy;
  assign launch  = (state == S_WAIT) && all_rdy;

  // Per-core start keys, wrapping modulo 2^KEY_W.
  generate
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_start
      assign core_key_start[i*KEY_W +: KEY_W] = key_base_q + KEY_W'(i);
    end
  endgenerate

  // Completion detection. In RUN the first cycle is skipped because cores
  // only drop core_rdy one cycle after their start pulse.
  always_comb begin
    done_mask = '0;
    valid_fin = '0;
    if (state == S_RUN && !first_run) begin
      done_mask = busy & core_rdy;
      valid_fin = done_mask & core_key_valid;
    end else if (state == S_ABORT) begin
      done_mask = busy & core_rdy;
    end
  end

  // Lowest-index valid finisher wins.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (valid_fin[PTR_W'(i)]) begin
        win_any = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
    win_key = core_key[win_idx*KEY_W +: KEY_W];
  end

  // Busy mask update: all set at launch, bits cleared as cores finish.
  always_comb begin
    busy_nxt = busy & ~done_mask;
    if (launch) begin
      busy_nxt = '1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_WAIT;
      S_WAIT:  if (all_rdy) state_nxt = S_RUN;
      S_RUN: begin
        if (win_any) begin
          state_nxt = S_ABORT;
        end else if (busy_nxt == '0) begin
          state_nxt = S_IDLE;
        end
      end
      S_ABORT: if (busy_nxt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    rdy        = (state == S_IDLE);
    core_en    = launch ? {NUM_CORES{1'b1}} : '0;
    core_abort = (state == S_ABORT) ? busy : '0;
  end

  // Job bookkeeping: base key, result key, busy mask, first-RUN flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_base_q <= '0;
      key        <= '0;
      key_valid  <= 1'b0;
      busy       <= '0;
      first_run  <= 1'b0;
    end else begin
      busy      <= busy_nxt;
      first_run <= launch;
      if (state == S_IDLE && en) begin
        key_base_q <= key_base;
        key_valid  <= 1'b0;
      end
      if (win_any) begin
        key       <= win_key;
        key_valid <= 1'b1;
      end
    end
  end

  // Round-robin search over busy requesters, starting at the pointer.
  assign eligible = (state == S_RUN) ? (core_ct_req & busy) : '0;

  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_CORES);
      if (!gnt_any && eligible[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign core_ct_gnt    = gnt;
  assign core_ct_rvalid = rvalid;
  assign ct_rddata_o    = ct_rddata;
  // Memory address is presented in the grant cycle; otherwise held.
  assign ct_addr        = gnt_any ? core_ct_addr[gnt_idx*ADDR_W +: ADDR_W] : addr_hold;

  // Arbiter state: pointer, held address and the one-cycle-late rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      addr_hold <= '0;
      rvalid    <= '0;
    end else begin
      rvalid <= gnt;
      if (gnt_any) begin
        addr_hold <= core_ct_addr[gnt_idx*ADDR_W +: ADDR_W];
        rr_ptr    <= (gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

`ifdef CRACK_SCHED_PERF_EN
  logic stall_cond;
  assign stall_cond = ($countones(core_ct_req & busy) >= 2);

  // Saturating busy-cycle and arbitration-stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == S_IDLE) begin
      if (en) begin
        perf_cycles <= '0;
        perf_stall  <= '0;
      end
    end else begin
      if (perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 32'd1;
      if (stall_cond && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_crack_sched.sv
//----------------------------------------------------------------------------
// Module      : tb_crack_sched
// Description : Directed self-checking bench for crack_sched (2 cores).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_crack_sched;

  localparam int NUM_CORES = 2;
  localparam int KEY_W     = 24;
  localparam int ADDR_W    = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        en;
  logic                        rdy;
  logic [KEY_W-1:0]            key_base;
  logic [KEY_W-1:0]            key;
  logic                        key_valid;
  logic [NUM_CORES-1:0]        core_en;
  logic [NUM_CORES-1:0]        core_abort;
  logic [NUM_CORES*KEY_W-1:0]  core_key_start;
  logic [NUM_CORES-1:0]        core_rdy;
  logic [NUM_CORES-1:0]        core_key_valid;
  logic [NUM_CORES*KEY_W-1:0]  core_key;
  logic [NUM_CORES-1:0]        core_ct_req;
  logic [NUM_CORES*ADDR_W-1:0] core_ct_addr;
  logic [NUM_CORES-1:0]        core_ct_gnt;
  logic [NUM_CORES-1:0]        core_ct_rvalid;
  logic [7:0]                  ct_rddata_o;
  logic [ADDR_W-1:0]           ct_addr;
  logic [7:0]                  ct_rddata;

  int checks = 0;
  int errors = 0;

  crack_sched #(
    .NUM_CORES(NUM_CORES),
    .KEY_W(KEY_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .rdy(rdy),
    .key_base(key_base),
    .key(key),
    .key_valid(key_valid),
    .core_en(core_en),
    .core_abort(core_abort),
    .core_key_start(core_key_start),
    .core_rdy(core_rdy),
    .core_key_valid(core_key_valid),
    .core_key(core_key),
    .core_ct_req(core_ct_req),
    .core_ct_addr(core_ct_addr),
    .core_ct_gnt(core_ct_gnt),
    .core_ct_rvalid(core_ct_rvalid),
    .ct_rddata_o(ct_rddata_o),
    .ct_addr(ct_addr),
    .ct_rddata(ct_rddata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step to the next falling edge; inputs change there, checks follow #1 later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  logic [1:0] exp_gnt [4];
  logic [7:0] exp_addr[4];

  initial begin
    exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr = '{8'h10, 8'h20, 8'h10, 8'h20};

    rst            = 1'b1;
    en             = 1'b0;
    key_base       = '0;
    core_rdy       = 2'b11;
    core_key_valid = 2'b00;
    core_key       = '0;
    core_ct_req    = 2'b00;
    core_ct_addr   = {8'h20, 8'h10};
    ct_rddata      = 8'h00;

    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    next_cycle(); #1;
    check("rst_rdy", 64'(rdy), 64'd1);
    check("rst_key", 64'(key), 64'd0);
    check("rst_kv", 64'(key_valid), 64'd0);
    check("rst_core_en", 64'(core_en), 64'd0);
    check("rst_abort", 64'(core_abort), 64'd0);
    check("rst_gnt", 64'(core_ct_gnt), 64'd0);
    check("rst_rvalid", 64'(core_ct_rvalid), 64'd0);
    check("rst_ct_addr", 64'(ct_addr), 64'd0);

    // ---------------- start handshake ----------------
    next_cycle();
    rst = 1'b0; en = 1'b1; key_base = 24'h000000;
    next_cycle();                         // now WAIT
    en = 1'b0; #1;
    check("hs_rdy_low", 64'(rdy), 64'd0);
    check("hs_core_en", 64'(core_en), 64'h3);
    check("hs_key_start", 64'(core_key_start), 64'h000001_000000);
    next_cycle();                         // first RUN cycle
    core_rdy = 2'b00; en = 1'b1; #1;      // en while busy must be ignored
    check("hs_core_en_once", 64'(core_en), 64'd0);
    next_cycle();
    en = 1'b0; #1;
    check("hs_en_ignored", 64'(rdy), 64'd0);

    // ---------------- arbitration ----------------
    ct_rddata = 8'h02;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) core_ct_req = 2'b11;
      #1;
      check("arb_gnt", 64'(core_ct_gnt), 64'(exp_gnt[i]));
      check("arb_addr", 64'(ct_addr), 64'(exp_addr[i]));
      check("arb_rvalid", 64'(core_ct_rvalid), (i == 0) ? 64'd0 : 64'(exp_gnt[i-1]));
      next_cycle();
    end
    core_ct_req = 2'b00; #1;
    check("arb_last_rvalid", 64'(core_ct_rvalid), 64'h2);
    check("arb_idle_gnt", 64'(core_ct_gnt), 64'd0);
    check("arb_addr_hold", 64'(ct_addr), 64'h20);
    check("arb_rddata", 64'(ct_rddata_o), 64'h02);

    // ---------------- found key, core0 still busy ----------------
    next_cycle();
    core_rdy = 2'b10; core_key_valid = 2'b10; core_key = {24'h000003, 24'h000000};
    next_cycle();                         // ABORT
    core_ct_req = 2'b11; #1;
    check("fk_key", 64'(key), 64'h3);
    check("fk_kv", 64'(key_valid), 64'd1);
    check("fk_abort", 64'(core_abort), 64'h1);
    check("fk_rdy", 64'(rdy), 64'd0);
    check("fk_no_gnt_abort", 64'(core_ct_gnt), 64'd0);
    next_cycle();
    core_ct_req = 2'b00; core_rdy = 2'b11; core_key_valid = 2'b00; #1;
    check("fk_abort_hold", 64'(core_abort), 64'h1);
    next_cycle(); #1;
    check("fk_rdy_back", 64'(rdy), 64'd1);
    check("fk_abort_off", 64'(core_abort), 64'd0);
    check("fk_key_hold", 64'(key), 64'h3);
    check("fk_kv_hold", 64'(key_valid), 64'd1);

    // ---------------- simultaneous find ----------------
    en = 1'b1; key_base = 24'h000100;
    next_cycle();                         // WAIT
    en = 1'b0; #1;
    check("sf_kv_clear", 64'(key_valid), 64'd0);
    check("sf_key_start", 64'(core_key_start), 64'h000101_000100);
    next_cycle();
    core_rdy = 2'b00;
    next_cycle();
    core_rdy = 2'b11; core_key_valid = 2'b11; core_key = {24'h000011, 24'h000010};
    next_cycle();
    core_key_valid = 2'b00; #1;
    check("sf_key", 64'(key), 64'h10);
    check("sf_kv", 64'(key_valid), 64'd1);
    check("sf_no_abort", 64'(core_abort), 64'd0);
    next_cycle(); #1;
    check("sf_rdy", 64'(rdy), 64'd1);
    check("sf_no_abort2", 64'(core_abort), 64'd0);

    // ---------------- exhaustion and wrap ----------------
    en = 1'b1; key_base = 24'hFFFFFF;
    next_cycle();                         // WAIT
    en = 1'b0; #1;
    check("ex_key_start_wrap", 64'(core_key_start), 64'h000000_FFFFFF);
    next_cycle();
    core_rdy = 2'b00;
    next_cycle();
    core_rdy = 2'b01;
    next_cycle(); #1;
    check("ex_still_busy", 64'(rdy), 64'd0);
    core_rdy = 2'b11;
    next_cycle(); #1;
    check("ex_rdy", 64'(rdy), 64'd1);
    check("ex_kv", 64'(key_valid), 64'd0);

    // ---------------- reset in RUN ----------------
    en = 1'b1; key_base = 24'h000000;
    next_cycle();
    en = 1'b0;
    next_cycle();                         // RUN
    core_rdy = 2'b00; core_ct_req = 2'b01; core_ct_addr = {8'h20, 8'h33}; #1;
    check("mr_gnt", 64'(core_ct_gnt), 64'h1);
    check("mr_addr", 64'(ct_addr), 64'h33);
    rst = 1'b1;
    next_cycle(); #1;
    check("mr_rdy", 64'(rdy), 64'd1);
    check("mr_gnt_clear", 64'(core_ct_gnt), 64'd0);
    check("mr_rvalid_clear", 64'(core_ct_rvalid), 64'd0);
    check("mr_addr_clear", 64'(ct_addr), 64'd0);
    rst = 1'b0; core_ct_req = 2'b00; core_rdy = 2'b11;

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crack_sched.md
Name: crack_sched

Overview:
- Controller that runs NUM_CORES ARC4 crack cores in parallel over a partitioned 24-bit key space.
- Core i starts at key_base+i and is built to step by NUM_CORES.
- Launches all cores, round-robin arbitrates the single shared ciphertext memory read port, and reports the first valid key.
- On the first valid key it aborts the remaining cores.
- Sits between the top level (rdy/en handshake) and the crack core array plus ciphertext memory.

Parameters:
NUM_CORES, 2, number of crack cores driven (1..8)
KEY_W, 24, key width in bits
ADDR_W, 8, ciphertext memory address width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
en  in  1  start pulse; sampled only while rdy=1
rdy  out  1  idle and ready to accept en
key_base  in  KEY_W  base key; sampled when en is accepted
key  out  KEY_W  found key
key_valid  out  1  key holds a valid cracked key
core_en  out  NUM_CORES  one-cycle start pulse per core
core_abort  out  NUM_CORES  level; forces core back to idle
core_key_start  out  NUM_CORES*KEY_W  per-core start key, slice i = key_base+i mod 2^KEY_W
core_rdy  in  NUM_CORES  core idle
core_key_valid  in  NUM_CORES  core found key (qualified by core_rdy)
core_key  in  NUM_CORES*KEY_W  per-core key result
core_ct_req  in  NUM_CORES  core requests ciphertext read
core_ct_addr  in  NUM_CORES*ADDR_W  per-core read address
core_ct_gnt  out  NUM_CORES  one-hot grant, same cycle as request
core_ct_rvalid  out  NUM_CORES  one-hot; data on ct_rddata_o is valid for that core
ct_rddata_o  out  8  shared read data broadcast to all cores
ct_addr  out  ADDR_W  ciphertext memory address
ct_rddata  in  8  ciphertext memory data; synchronous, 1-cycle latency

Behaviour:
- Reset values (cycle after rst=1): state IDLE, rdy=1, key=0, key_valid=0, core_en=0, core_abort=0, core_ct_gnt=0, core_ct_rvalid=0, ct_addr=0, round-robin pointer=0, busy mask=0.
- rst mid-operation returns to IDLE in one cycle. Cores are not aborted by this block; they share rst.
- States:
  - IDLE: rdy=1. On en=1, latch key_base, clear key_valid, go to WAIT.
  - WAIT: rdy=0. When all core_rdy=1, pulse core_en on all cores for exactly one cycle, set busy mask to all ones, go to RUN.
  - RUN: a core is finished when busy[i]=1 and core_rdy[i]=1, evaluated from the second RUN cycle onward. On finish, clear busy[i].
    - If core_key_valid[i]=1: latch key=core_key[i], key_valid=1, go to ABORT. If several cores finish valid in the same cycle, the lowest index wins.
    - If the busy mask reaches 0 with no valid finish: key_valid=0, go to IDLE.
  - ABORT: core_abort=1 on every core whose busy bit is still set. Clear busy[i] when core_rdy[i]=1. When busy mask=0, deassert core_abort and go to IDLE.
- Return to IDLE sets rdy=1 in the same cycle as the transition. key and key_valid hold until the next accepted en.
- en while rdy=0 is ignored.
- Arbitration:
  - Combinational round-robin over core_ct_req masked by busy. At most one grant per cycle.
  - Search starts at pointer. After a grant to core g, pointer = g+1 mod NUM_CORES.
  - ct_addr = granted core's address, or holds its previous value when there is no grant.
  - core_ct_rvalid[g] is asserted exactly one cycle after core_ct_gnt[g]; ct_rddata_o = ct_rddata.
  - A core must hold req and addr until granted. A granted request is consumed.
  - No grants are issued in IDLE, WAIT or ABORT. A pending rvalid still completes in the cycle after its grant.
- Key arithmetic: key_base+i is truncated to KEY_W, so 0xFFFFFF+1 wraps to 0x000000.

Optional Feature:
- Macro CRACK_SCHED_PERF_EN. When defined, adds two outputs:
  - perf_cycles (32-bit): cleared on accepted en, increments every non-IDLE cycle, saturates at 0xFFFFFFFF, holds in IDLE.
  - perf_stall (32-bit): counts cycles with ≥2 requests pending among busy cores, same clear, saturation and hold rules as perf_cycles.
- When undefined, neither port nor its logic exists and behaviour is otherwise identical.

Test Plan:
- Reset/handshake: rst=1 for 2 cycles, then en=1 with key_base=0x000000 → next cycle rdy=0. core_en=2'b11 pulses once, core_key_start = {0x000001, 0x000000}. en pulsed again while busy is ignored.
- Arbitration: both cores hold req, addr0=0x10, addr1=0x20 → grants alternate 01,10,01,10. ct_addr alternates 0x10/0x20. rvalid follows each grant by one cycle. With ct_rddata=0x02, ct_rddata_o=0x02.
- Found key: core1 finishes with core_key_valid=1, core_key=0x000003, while core0 busy → key=0x000003, key_valid=1. core_abort=2'b01 until core0 rdy, then rdy=1.
- Simultaneous find: both cores finish valid the same cycle with keys 0x000010/0x000011 → key=0x000010 (core 0 wins), no abort asserted.
- Exhaustion and wrap: key_base=0xFFFFFF gives core1 start 0x000000. Both finish with key_valid=0 → rdy=1, key_valid=0. Then rst=1 mid-RUN → IDLE, grants cleared next cycle.
